relogio_ctrl: RTL

RELOGIO_CTRL -- requirements
Module: relogio_ctrl

---
 rtl/relogio_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/relogio_ctrl.sv
// Digital clock controller: 1 Hz timebase, set-mode FSM with blink,
// and a time-multiplexed feed for one shared binary-to-BCD decoder.
module relogio_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int MUX_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [1:0] mode,
  output logic       tick_1hz,
  output logic       blink,
  output logic [1:0] dec_sel,
  output logic [5:0] dec_in
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);
  localparam logic [SW-1:0] S_LAST = SW'(MUX_DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [SW-1:0] slot;
  logic          mode_prev;
  logic          inc_prev;
  logic          mode_p;
  logic          inc_p;
  logic          p_wrap;

  assign mode_p = btn_mode & ~mode_prev;
  assign inc_p  = btn_inc & ~inc_prev;
  assign p_wrap = (presc == P_LAST);

  assign mode     = state;
  assign tick_1hz = (state == RUN) & p_wrap;
  assign blink    = (state != RUN) & (presc < P_HALF);

  // Time, prescaler and FSM share one block so the
  // set-min exit can clear sec and presc on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      presc     <= '0;
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      presc     <= p_wrap ? '0 : presc + 1'b1;
      unique case (state)
        RUN: begin
          if (p_wrap) begin
            if (sec == 6'd59) begin
              sec <= '0;
              if (min == 6'd59) begin
                min  <= '0;
                hour <= (hour == 5'd23) ? '0 : hour + 5'd1;
              end else begin
                min <= min + 6'd1;
              end
            end else begin
              sec <= sec + 6'd1;
            end
          end
          if (mode_p) state <= SET_HOUR;
        end
        SET_HOUR: begin
          if (mode_p) begin
            state <= SET_MIN;
          end else if (inc_p) begin
            hour <= (hour == 5'd23) ? '0 : hour + 5'd1;
          end
        end
        SET_MIN: begin
          if (mode_p) begin
            state <= RUN;
            sec   <= '0;
            presc <= '0;
          end else if (inc_p) begin
            min <= (min == 6'd59) ? '0 : min + 6'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot    <= '0;
      dec_sel <= 2'b00;
    end else if (slot == S_LAST) begin
      slot    <= '0;
      dec_sel <= (dec_sel == 2'b10) ? 2'b00 : dec_sel + 2'b01;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  always_comb begin
    dec_in = '0;
    unique case (1'b1)
      (dec_sel == 2'b00): dec_in = sec;
      (dec_sel == 2'b01): dec_in = min;
      (dec_sel == 2'b10): dec_in = {1'b0, hour};
      default:            dec_in = '0;
    endcase
  end

endmodule
